// File: rtl/serial_pkg.sv
// Shared types and constants for the serial deserializer: FSM state encoding,
// line-level start/stop bit values and the default word width.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   DEFAULT_DATA_W = 8;

endpackage

// File: rtl/serial_deserializer_if.sv
// Bundles the serial line, bit strobe, word handshake and error pulses
// between a deserializer and its driver/consumer.
interface serial_deserializer_if #(
  parameter int DATA_W = serial_pkg::DEFAULT_DATA_W
);
  logic              ser_in;
  logic              bit_en;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              busy;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  // Driver side: owns the line and the consumer ready
  modport master (
    output ser_in, bit_en, ready,
    input  data, valid, busy, parity_err, frame_err, overrun
  );

  // Deserializer side
  modport slave (
    input  ser_in, bit_en, ready,
    output data, valid, busy, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/serial_deserializer.sv
// Strobe-driven serial-to-parallel receiver: start bit, DATA_W data bits,
// optional even parity, stop bit; one-word output buffer with ready/valid.
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ser_in,
  input  logic              i_bit_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_par_err;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_overrun;

  logic [DATA_W-1:0] w_shift_next;
  logic              w_last_bit;

  generate
    if (DATA_W == 1) begin : g_shift_one
      assign w_shift_next = i_ser_in;
    end else if (MSB_FIRST != 0) begin : g_shift_msb
      assign w_shift_next = {r_shift[DATA_W-2:0], i_ser_in};
    end else begin : g_shift_lsb
      assign w_shift_next = {i_ser_in, r_shift[DATA_W-1:1]};
    end
  endgenerate

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_par_err    <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;

      // A completing good frame in STOP may override this clear with a reload
      if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end

      if (i_bit_en) begin
        unique case (r_state)
          S_IDLE: begin
            if (i_ser_in == START_BIT) begin
              r_state   <= S_DATA;
              r_cnt     <= '0;
              r_shift   <= '0;
              r_par     <= 1'b0;
              r_par_err <= 1'b0;
            end
          end
          S_DATA: begin
            r_shift <= w_shift_next;
            r_par   <= r_par ^ i_ser_in;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last_bit) begin
              r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            r_par_err <= r_par ^ i_ser_in;
            r_state   <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (i_ser_in != STOP_BIT) begin
              r_frame_err <= 1'b1;
            end else if (r_par_err) begin
              r_parity_err <= 1'b1;
            end else if (!r_valid || i_ready) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (DATA_W=8, even parity, MSB first):
// good frame, parity/frame errors, overrun, reload, sparse strobes, mid-frame reset.
module tb_serial_deserializer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   n_perr;
  int   n_ferr;
  int   n_ovr;
  int   n_accept;

  serial_deserializer_if #(.DATA_W(8)) bus ();

  serial_deserializer #(
    .DATA_W   (8),
    .PARITY_EN(1),
    .MSB_FIRST(1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ser_in    (bus.ser_in),
    .i_bit_en    (bus.bit_en),
    .o_data      (bus.data),
    .o_valid     (bus.valid),
    .i_ready     (bus.ready),
    .o_busy      (bus.busy),
    .o_parity_err(bus.parity_err),
    .o_frame_err (bus.frame_err),
    .o_overrun   (bus.overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and handshake counters sampled away from the active edge
  always @(negedge clk) begin
    if (bus.parity_err) n_perr++;
    if (bus.frame_err) n_ferr++;
    if (bus.overrun) n_ovr++;
    if (bus.valid && bus.ready) n_accept++;
  end

  task automatic drive_bit(input logic b, input int idle_cycles);
    for (int k = 0; k < idle_cycles; k++) begin
      bus.bit_en = 1'b0;
      bus.ser_in = ~b;
      @(posedge clk);
      #1;
    end
    bus.ser_in = b;
    bus.bit_en = 1'b1;
    @(posedge clk);
    #1;
    bus.bit_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int idle_cycles, input logic ready_at_stop);
    drive_bit(1'b0, idle_cycles);
    for (int i = 7; i >= 0; i--) drive_bit(d[i], idle_cycles);
    drive_bit(par, idle_cycles);
    bus.ready = ready_at_stop;
    drive_bit(stop, idle_cycles);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ser_in = 1'b1;
    bus.bit_en = 1'b0;
    bus.ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.data); end
    checks++;
    if ({bus.valid, bus.busy, bus.parity_err, bus.frame_err, bus.overrun} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {bus.valid, bus.busy, bus.parity_err, bus.frame_err, bus.overrun});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_good_frame();
    int acc0;
    acc0 = n_accept;
    bus.ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1);
    checks++;
    if (bus.valid !== 1'b1) begin failures++; $display("FAIL good_valid got=%b exp=1", bus.valid); end
    checks++;
    if (bus.data !== 8'hA5) begin failures++; $display("FAIL good_data got=%h exp=a5", bus.data); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL good_busy got=%b exp=0", bus.busy); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.valid !== 1'b0) begin failures++; $display("FAIL good_valid_clear got=%b exp=0", bus.valid); end
    checks++;
    if (n_accept - acc0 !== 1) begin failures++; $display("FAIL good_accepts got=%0d exp=1", n_accept - acc0); end
    $display("test_good_frame data=%h", bus.data);
  endtask

  task automatic test_parity_error();
    int p0;
    p0 = n_perr;
    send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b1);
    checks++;
    if (bus.parity_err !== 1'b1) begin failures++; $display("FAIL perr_pulse got=%b exp=1", bus.parity_err); end
    checks++;
    if (bus.valid !== 1'b0) begin failures++; $display("FAIL perr_valid got=%b exp=0", bus.valid); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n_perr - p0 !== 1) begin failures++; $display("FAIL perr_count got=%0d exp=1", n_perr - p0); end
    $display("test_parity_error pulses=%0d", n_perr - p0);
  endtask

  task automatic test_frame_error();
    int f0;
    f0 = n_ferr;
    send_frame(8'h81, 1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL ferr_pulse got=%b exp=1", bus.frame_err); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.valid !== 1'b0) begin failures++; $display("FAIL ferr_valid got=%b exp=0", bus.valid); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n_ferr - f0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - f0); end
    $display("test_frame_error pulses=%0d", n_ferr - f0);
  endtask

  task automatic test_overrun();
    int o0;
    o0 = n_ovr;
    bus.ready = 1'b0;
    send_frame(8'h12, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h12) begin
      failures++; $display("FAIL ovr_first got=%b/%h exp=1/12", bus.valid, bus.data);
    end
    send_frame(8'h34, 1'b1, 1'b1, 0, 1'b0);
    checks++;
    if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse got=%b exp=1", bus.overrun); end
    checks++;
    if (bus.data !== 8'h12) begin failures++; $display("FAIL ovr_data got=%h exp=12", bus.data); end
    @(posedge clk);
    #1;
    checks++;
    if (n_ovr - o0 !== 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", n_ovr - o0); end
    bus.ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_clear got=%b exp=0", bus.valid); end
    $display("test_overrun data=%h overruns=%0d", bus.data, n_ovr - o0);
  endtask

  task automatic test_back_to_back_reload();
    int o0;
    o0 = n_ovr;
    bus.ready = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1, 0, 1'b1);
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h0F) begin
      failures++; $display("FAIL reload_word got=%b/%h exp=1/0f", bus.valid, bus.data);
    end
    checks++;
    if (n_ovr - o0 !== 0 || bus.overrun !== 1'b0) begin
      failures++; $display("FAIL reload_overrun got=%0d exp=0", n_ovr - o0);
    end
    @(posedge clk);
    #1;
    $display("test_back_to_back_reload data=%h", bus.data);
  endtask

  task automatic test_sparse();
    logic [7:0] d;
    int bad_busy;
    d = 8'hF0;
    bus.ready = 1'b1;
    drive_bit(1'b0, 3);
    for (int i = 7; i >= 4; i--) drive_bit(d[i], 3);
    bad_busy = 0;
    for (int k = 0; k < 20; k++) begin
      bus.bit_en = 1'b0;
      bus.ser_in = k[0];
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b1 || bus.valid !== 1'b0) bad_busy++;
    end
    checks++;
    if (bad_busy !== 0) begin failures++; $display("FAIL sparse_freeze got=%0d exp=0", bad_busy); end
    for (int i = 3; i >= 0; i--) drive_bit(d[i], 3);
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 3);
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 8'hF0) begin
      failures++; $display("FAIL sparse_word got=%b/%h exp=1/f0", bus.valid, bus.data);
    end
    @(posedge clk);
    #1;
    $display("test_sparse data=%h", bus.data);
  endtask

  task automatic test_mid_reset();
    int p0;
    int f0;
    int o0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    bus.ready = 1'b1;
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_async_busy got=%b exp=0", bus.busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b1);
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h5A) begin
      failures++; $display("FAIL midrst_word got=%b/%h exp=1/5a", bus.valid, bus.data);
    end
    @(posedge clk);
    #1;
    checks++;
    if ((n_perr - p0) + (n_ferr - f0) + (n_ovr - o0) !== 0) begin
      failures++; $display("FAIL midrst_errors got=%0d exp=0", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0));
    end
    $display("test_mid_reset data=%h", bus.data);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_perr   = 0;
    n_ferr   = 0;
    n_ovr    = 0;
    n_accept = 0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_error();
    test_overrun();
    test_back_to_back_reload();
    test_sparse();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 The block SHALL take a parameter DATA_W, default 8, giving the data bits per frame and the output byte width.
REQ-002 The block SHALL take a parameter PARITY_EN, default 1, where 1 means an even-parity bit follows the data bits and 0 means no parity bit.
REQ-003 The block SHALL take a parameter MSB_FIRST, default 1, where 1 means the first data bit received is o_data[DATA_W-1] and 0 means it is o_data[0].
REQ-004 Port i_clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port i_rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-006 Port i_ser_in SHALL be an input, 1 bit: serial line from the upstream shift register's o_ser_out.
REQ-007 Port i_bit_en SHALL be an input, 1 bit: bit strobe, sampled only on cycles where it is 1.
REQ-008 Port o_data SHALL be an output, DATA_W bits: received word.
REQ-009 Port o_valid SHALL be an output, 1 bit: o_data holds an unconsumed word.
REQ-010 Port i_ready SHALL be an input, 1 bit: consumer accepts o_data on a cycle where o_valid=1 and i_ready=1.
REQ-011 Port o_busy SHALL be an output, 1 bit: 1 whenever the FSM is not IDLE.
REQ-012 Port o_parity_err SHALL be an output, 1 bit: one-cycle pulse on parity mismatch.
REQ-013 Port o_frame_err SHALL be an output, 1 bit: one-cycle pulse on a stop bit of 0.
REQ-014 Port o_overrun SHALL be an output, 1 bit: one-cycle pulse when a good frame is dropped.

Function
REQ-015 Frame format SHALL be: start bit 0, then DATA_W data bits, then the parity bit if PARITY_EN=1, then stop bit 1; only strobed cycles advance the frame.
REQ-016 FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-017 IDLE->DATA SHALL occur on a strobe with i_ser_in=0, clearing the bit counter; a strobe with i_ser_in=1 SHALL stay in IDLE.
REQ-018 DATA SHALL shift in one bit per strobe per MSB_FIRST; after DATA_W strobes it SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-019 PARITY SHALL capture one bit on a strobe and go to STOP; a parity mismatch SHALL set an internal error flag.
REQ-020 Parity SHALL be even: the XOR of the data bits and the parity bit must be 0.
REQ-021 STOP SHALL act on a strobe and always return to IDLE.
REQ-022 In STOP, if the stop bit is 1 and the parity flag is clear, the frame SHALL be a good frame.
REQ-023 In STOP, if the stop bit is 0, o_frame_err SHALL pulse on the following cycle and the data SHALL be discarded.
REQ-024 In STOP, if the stop bit is 1 but the parity flag is set, o_parity_err SHALL pulse on the following cycle and the data SHALL be discarded.
REQ-025 On a good frame, o_data SHALL load and o_valid SHALL rise one cycle after the clock edge that sampled the stop bit.
REQ-026 o_valid and o_data SHALL hold until a handshake; o_valid SHALL clear on the edge ending the handshake cycle unless a reload occurs on that same edge.
REQ-027 If a good frame completes while o_valid=1 and i_ready=1, the new word SHALL load and o_valid SHALL stay 1.
REQ-028 If a good frame completes while o_valid=1 and i_ready=0, the new word SHALL be dropped, o_data SHALL be kept, and o_overrun SHALL pulse for one cycle.
REQ-029 i_bit_en=0 SHALL freeze the FSM, counter and shifter, with no timeout.
REQ-030 A frame SHALL take DATA_W+2+PARITY_EN strobes; back-to-back frames SHALL be accepted with no idle strobe between them.

Reset
REQ-031 When i_rst=1, the FSM SHALL go to IDLE and the counter, shifter and parity flag SHALL clear, asynchronously.
REQ-032 Reset values SHALL be o_data=0, o_valid=0, o_busy=0 and all error pulses 0.
REQ-033 A reset during a frame SHALL discard the partial frame, and the next start bit SHALL be decoded cleanly.

Structure
REQ-034 Package serial_pkg SHALL hold the FSM state typedef, the START_BIT=0 and STOP_BIT=1 constants, and the default DATA_W.
REQ-035 The block SHALL be flat with no sub-module; the bit counter width SHALL be $clog2(DATA_W+1).

Verification
REQ-036 Good frame: after reset, strobe every cycle with frame 0, 0xA5 MSB-first, parity 0, stop 1, i_ready=1 -> o_data=0xA5 and o_valid high for one cycle, 1 cycle after the stop strobe.
REQ-037 Parity error: send 0x3C with parity 1 -> one o_parity_err pulse, o_valid stays 0.
REQ-038 Frame error: send 0x81 with parity 0 and stop 0 -> one o_frame_err pulse, and the FSM is IDLE with o_busy=0.
REQ-039 Overrun: i_ready=0, send 0x12 then 0x34 back-to-back -> o_data=0x12, one o_overrun pulse; then i_ready=1 -> o_valid clears.
REQ-040 Sparse strobes: i_bit_en high 1 cycle in 4, send 0xF0 -> o_data=0xF0, and the state does not change on non-strobe cycles.
REQ-041 Mid-frame reset: assert i_rst after 4 data bits, release, send 0x5A -> o_data=0x5A with no error pulses.
